// File: rtl/mem_arb2_pkg.sv
// Shared defaults, state encoding and grant type for the two-requester RAM arbiter.
package mem_arb2_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 12;
  localparam int WORDS_DEF  = 4096;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } gnt_e;

endpackage

// File: rtl/mem_arb2_if.sv
// Requester A/B handshakes, read responses and the external RAM port of mem_arb2.
interface mem_arb2_if #(
  parameter int DWIDTH = mem_arb2_pkg::DWIDTH_DEF,
  parameter int AWIDTH = mem_arb2_pkg::AWIDTH_DEF
) ();

  logic              init_done;
  logic              a_valid;
  logic              b_valid;
  logic              a_ready;
  logic              b_ready;
  logic              a_we;
  logic              b_we;
  logic [AWIDTH-1:0] a_addr;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] a_wdata;
  logic [DWIDTH-1:0] b_wdata;
  logic              a_rvalid;
  logic              b_rvalid;
  logic [DWIDTH-1:0] a_rdata;
  logic [DWIDTH-1:0] b_rdata;
  logic              mem_load;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_d;
  logic [DWIDTH-1:0] mem_q;

  modport slave (
    input  a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_q,
    output init_done, a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output mem_load, mem_addr, mem_d
  );

  modport master (
    output a_valid, b_valid, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_q,
    input  init_done, a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  mem_load, mem_addr, mem_d
  );

endinterface

// File: rtl/mem_arb2_rr_pick2.sv
// Two-way round-robin pick: valids plus priority flag give the grant and the next priority.
module rr_pick2
  import mem_arb2_pkg::*;
(
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_prio_b,
  output gnt_e o_grant,
  output logic o_prio_b_nxt
);

  // A lone requester always wins; a tie goes to the priority holder
  always_comb begin
    o_grant = GNT_NONE;
    if (i_a_valid && i_b_valid) begin
      o_grant = i_prio_b ? GNT_B : GNT_A;
    end else if (i_a_valid) begin
      o_grant = GNT_A;
    end else if (i_b_valid) begin
      o_grant = GNT_B;
    end else begin
      o_grant = GNT_NONE;
    end
  end

  // Priority moves to the requester that lost (or sat out) the latest grant
  always_comb begin
    o_prio_b_nxt = i_prio_b;
    case (o_grant)
      GNT_A:   o_prio_b_nxt = 1'b1;
      GNT_B:   o_prio_b_nxt = 1'b0;
      default: o_prio_b_nxt = i_prio_b;
    endcase
  end

endmodule

// File: rtl/mem_arb2.sv
// Clears the external RAM after reset, then arbitrates requesters A and B onto it,
// returning read data one cycle after each read grant.
module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb2_if.slave bus
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(WORDS - 1);

  logic [0:0]        r_state;
  logic [AWIDTH-1:0] r_cnt;
  logic              r_init_done;
  logic              r_prio_b;
  logic              r_a_pend;
  logic              r_b_pend;
  logic              w_run;
  gnt_e              w_grant;
  logic              w_prio_b_nxt;

  assign w_run = (r_state == ST_RUN);

  rr_pick2 u_pick (
    .i_a_valid    (bus.a_valid & w_run),
    .i_b_valid    (bus.b_valid & w_run),
    .i_prio_b     (r_prio_b),
    .o_grant      (w_grant),
    .o_prio_b_nxt (w_prio_b_nxt)
  );

  assign bus.a_ready   = (w_grant == GNT_A);
  assign bus.b_ready   = (w_grant == GNT_B);
  assign bus.init_done = r_init_done;
  assign bus.a_rvalid  = r_a_pend;
  assign bus.b_rvalid  = r_b_pend;
  assign bus.a_rdata   = r_a_pend ? bus.mem_q : {DWIDTH{1'b0}};
  assign bus.b_rdata   = r_b_pend ? bus.mem_q : {DWIDTH{1'b0}};

  // Clear sweep counter, INIT->RUN transition and round-robin priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= {AWIDTH{1'b0}};
      r_init_done <= 1'b0;
      r_prio_b    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + AWIDTH'(1);
          if (r_cnt == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_prio_b <= w_prio_b_nxt;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Remember which requester owns the RAM read data arriving next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_pend <= 1'b0;
      r_b_pend <= 1'b0;
    end else begin
      r_a_pend <= (w_grant == GNT_A) & ~bus.a_we;
      r_b_pend <= (w_grant == GNT_B) & ~bus.b_we;
    end
  end

  // RAM port: zero-fill during INIT (held off while reset is asserted), granted request in RUN
  always_comb begin
    bus.mem_load = 1'b0;
    bus.mem_addr = {AWIDTH{1'b0}};
    bus.mem_d    = {DWIDTH{1'b0}};
    if (!w_run) begin
      bus.mem_load = rst_n;
      bus.mem_addr = r_cnt;
      bus.mem_d    = {DWIDTH{1'b0}};
    end else begin
      case (w_grant)
        GNT_A: begin
          bus.mem_load = bus.a_we;
          bus.mem_addr = bus.a_addr;
          bus.mem_d    = bus.a_wdata;
        end
        GNT_B: begin
          bus.mem_load = bus.b_we;
          bus.mem_addr = bus.b_addr;
          bus.mem_d    = bus.b_wdata;
        end
        default: begin
          bus.mem_load = 1'b0;
          bus.mem_addr = {AWIDTH{1'b0}};
          bus.mem_d    = {DWIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Self-checking bench for mem_arb2: clear sweeps, directed vector table, resets and
// randomized traffic against a request-level reference model with its own RAM image.
module tb_mem_arb2;
  import mem_arb2_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int WORDS = 4096;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb2_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  mem_arb2 #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External RAM with registered read data
  logic [DW-1:0] ram [WORDS];
  always @(posedge clk) begin
    if (bus.mem_load) ram[bus.mem_addr] <= bus.mem_d;
    bus.mem_q <= ram[bus.mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input logic ar, input logic br, input logic ld,
                          input logic [AW-1:0] ma, input logic [DW-1:0] md,
                          input logic arv, input logic brv,
                          input logic [DW-1:0] ard, input logic [DW-1:0] brd);
    chk({tag, ".a_ready"},  32'(bus.a_ready),  32'(ar));
    chk({tag, ".b_ready"},  32'(bus.b_ready),  32'(br));
    chk({tag, ".mem_load"}, 32'(bus.mem_load), 32'(ld));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(ma));
    chk({tag, ".mem_d"},    32'(bus.mem_d),    32'(md));
    chk({tag, ".a_rvalid"}, 32'(bus.a_rvalid), 32'(arv));
    chk({tag, ".b_rvalid"}, 32'(bus.b_rvalid), 32'(brv));
    chk({tag, ".a_rdata"},  32'(bus.a_rdata),  32'(ard));
    chk({tag, ".b_rdata"},  32'(bus.b_rdata),  32'(brd));
  endtask

  task automatic set_in(input logic av, input logic bv, input logic awe, input logic bwe,
                        input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                        input logic [DW-1:0] awd, input logic [DW-1:0] bwd);
    bus.a_valid = av;  bus.b_valid = bv;
    bus.a_we    = awe; bus.b_we    = bwe;
    bus.a_addr  = aa;  bus.b_addr  = ba;
    bus.a_wdata = awd; bus.b_wdata = bwd;
  endtask

  // Asserts reset at the current time, checks the asynchronous clear, releases on a falling edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_mem_load"},  32'(bus.mem_load),  32'd0);
    chk({tag, ".rst_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, ".rst_init_done"}, 32'(bus.init_done), 32'd0);
    chk({tag, ".rst_ready"},     32'({bus.a_ready, bus.b_ready}),   32'd0);
    chk({tag, ".rst_rvalid"},    32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    chk({tag, ".rst_rdata"},     32'(bus.a_rdata | bus.b_rdata),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at the release edge; the clear must write 0 to every address in order
  task automatic sweep(input string tag);
    int bad = 0;
    for (int i = 0; i < WORDS; i++) begin
      #2;
      if (bus.mem_load !== 1'b1 || bus.mem_addr !== AW'(i) || bus.mem_d !== '0 ||
          bus.init_done !== 1'b0 || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 ||
          bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin
        if (bad == 0)
          $display("%s: first bad sweep cycle %0d (load=%b addr=0x%0h d=0x%0h done=%b)",
                   tag, i, bus.mem_load, bus.mem_addr, bus.mem_d, bus.init_done);
        bad++;
      end
      @(negedge clk);
    end
    chk({tag, ".sweep_bad_cycles"}, 32'(bad), 32'd0);
    #2;
    chk({tag, ".init_done_after_4096"}, 32'(bus.init_done), 32'd1);
  endtask

  typedef struct {
    logic av, bv, awe, bwe;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] awd, bwd;
    logic ar, br, ld;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic arv, brv;
    logic [DW-1:0] ard, brd;
  } vec_t;

  vec_t vt [14];

  typedef struct {
    logic          is_b;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          rsp_q [$];
  logic [DW-1:0] model_mem [WORDS];
  logic          last_won_a;

  initial begin
    rsp_t r;
    logic av, bv, awe, bwe;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] awd, bwd;
    logic arv, brv;
    logic [DW-1:0] ard, brd;
    int win;
    int sel;

    //                av    bv    awe   bwe   aa       ba       awd       bwd        ar    br    ld    ma       md        arv   brv   ard       brd
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 16'h0BAD, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0BAD, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 12'h020, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1, 12'h020, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0BAD, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b1, 1'b0, 16'h1234, 16'h0000};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0BAD, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b1, 1'b0, 16'h1234, 16'h0000};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0BAD, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 12'h020, 16'h0BAD, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b1, 1'b0, 16'h1234, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h020, 16'h0000, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h020, 16'h0000, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h020, 16'h0000, 16'h0B0B, 1'b0, 1'b1, 1'b0, 12'h020, 16'h0B0B, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};

    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #3;
    do_reset("por");
    sweep("por");

    // Reset in the middle of the clear, with A already waiting to write 0x1234 at 0x010
    do_reset("run_rst");
    repeat (100) @(negedge clk);
    #2;
    chk("mid_init.mem_addr", 32'(bus.mem_addr), 32'd100);
    chk("mid_init.init_done", 32'(bus.init_done), 32'd0);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 12'h010, '0, 16'h1234, '0);
    do_reset("mid_init");
    sweep("mid_init");
    chk_outs("first_run", 1'b1, 1'b0, 1'b1, 12'h010, 16'h1234, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].av, vt[i].bv, vt[i].awe, vt[i].bwe, vt[i].aa, vt[i].ba, vt[i].awd, vt[i].bwd);
      #2;
      chk_outs($sformatf("row%0d", i), vt[i].ar, vt[i].br, vt[i].ld, vt[i].ma, vt[i].md,
               vt[i].arv, vt[i].brv, vt[i].ard, vt[i].brd);
      @(negedge clk);
    end

    // Reference model state after the table: B won last, two words written
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    model_mem[12'h010] = 16'h1234;
    model_mem[12'h020] = 16'hBEEF;
    last_won_a = 1'b0;

    for (int c = 0; c <= NRAND; c++) begin
      if (c == NRAND) begin
        av = 1'b0; bv = 1'b0; awe = 1'b0; bwe = 1'b0; aa = '0; ba = '0; awd = '0; bwd = '0;
      end else begin
        av  = ($urandom_range(0, 3) != 0);
        bv  = ($urandom_range(0, 3) != 0);
        awe = $urandom_range(0, 1) == 1;
        bwe = $urandom_range(0, 1) == 1;
        sel = $urandom_range(0, 10);
        aa  = (sel == 8) ? 12'h010 : (sel == 9) ? 12'h020 : (sel == 10) ? 12'hFFF : AW'(sel);
        sel = $urandom_range(0, 10);
        ba  = (sel == 8) ? 12'h010 : (sel == 9) ? 12'h020 : (sel == 10) ? 12'hFFF : AW'(sel);
        awd = DW'($urandom);
        bwd = DW'($urandom);
      end
      set_in(av, bv, awe, bwe, aa, ba, awd, bwd);
      #2;
      arv = 1'b0; brv = 1'b0; ard = '0; brd = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == c) begin
        r = rsp_q.pop_front();
        if (r.is_b) begin brv = 1'b1; brd = r.data; end
        else begin arv = 1'b1; ard = r.data; end
      end
      if (av && bv) win = last_won_a ? 2 : 1;
      else if (av)  win = 1;
      else if (bv)  win = 2;
      else          win = 0;
      if (win == 1)
        chk_outs($sformatf("rnd%0d", c), 1'b1, 1'b0, awe, aa, awd, arv, brv, ard, brd);
      else if (win == 2)
        chk_outs($sformatf("rnd%0d", c), 1'b0, 1'b1, bwe, ba, bwd, arv, brv, ard, brd);
      else
        chk_outs($sformatf("rnd%0d", c), 1'b0, 1'b0, 1'b0, '0, '0, arv, brv, ard, brd);
      if (win == 1) begin
        last_won_a = 1'b1;
        if (awe) model_mem[aa] = awd;
        else rsp_q.push_back('{1'b0, model_mem[aa], c + 1});
      end else if (win == 2) begin
        last_won_a = 1'b0;
        if (bwe) model_mem[ba] = bwd;
        else rsp_q.push_back('{1'b1, model_mem[ba], c + 1});
      end
      @(negedge clk);
    end
    chk("rnd.responses_left", 32'(rsp_q.size()), 32'd0);

    // Reset while a B read response is on the bus: it must vanish and the clear re-runs
    set_in(1'b0, 1'b1, 1'b0, 1'b0, '0, 12'h020, '0, '0);
    #2;
    chk("b_read_before_rst.b_ready", 32'(bus.b_ready), 32'd1);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #2;
    chk("b_read_before_rst.b_rvalid", 32'(bus.b_rvalid), 32'd1);
    chk("b_read_before_rst.b_rdata", 32'(bus.b_rdata), 32'(model_mem[12'h020]));
    do_reset("inflight");
    sweep("inflight");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter DWIDTH, 16, data width of the shared RAM word.
REQ-002 Parameter AWIDTH, 12, RAM address width.
REQ-003 Parameter WORDS, 4096, number of RAM words to initialise; SHALL equal 2**AWIDTH.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 init_done  output  1  high once the RAM clear sequence has finished.
REQ-007 a_valid, b_valid  input  1  requester A/B request valid.
REQ-008 a_ready, b_ready  output  1  requester A/B request accepted this cycle.
REQ-009 a_we, b_we  input  1  1 = write, 0 = read.
REQ-010 a_addr, b_addr  input  AWIDTH  request address.
REQ-011 a_wdata, b_wdata  input  DWIDTH  write data.
REQ-012 a_rvalid, b_rvalid  output  1  read data valid for requester A/B.
REQ-013 a_rdata, b_rdata  output  DWIDTH  read data.
REQ-014 mem_load  output  1  RAM write enable.
REQ-015 mem_addr  output  AWIDTH  RAM address.
REQ-016 mem_d  output  DWIDTH  RAM write data.
REQ-017 mem_q  input  DWIDTH  RAM registered read data, valid one cycle after the address is presented.

Function
REQ-018 FSM states: INIT and RUN; reset enters INIT with clear counter = 0.
REQ-019 INIT: each cycle mem_load=1, mem_addr=counter, mem_d=0, counter+1; a_ready=b_ready=0.
REQ-020 INIT->RUN on the cycle counter==WORDS-1 is written; init_done=1 from the next cycle; RUN is terminal until reset.
REQ-021 RUN: a handshake occurs when x_valid && x_ready; at most one of a_ready/b_ready is high per cycle.
REQ-022 x_ready is combinational from a_valid, b_valid and the priority pointer; ready is never high without its valid.
REQ-023 Arbitration is round-robin: when only one is valid it is granted; when both are valid, the requester not granted most recently wins; the pointer updates only on a grant; after reset A has priority.
REQ-024 Throughput: one accepted request per cycle; no idle cycles between grants.
REQ-025 On a grant: mem_addr=granted addr, mem_d=granted wdata, mem_load=granted we, all combinational in the grant cycle.
REQ-026 Without a grant in RUN: mem_load=0, mem_addr=0, mem_d=0.
REQ-027 A granted read gives x_rvalid=1 exactly one cycle later, with x_rdata=mem_q in that cycle. The non-owning rvalid is 0.
REQ-028 x_rdata = 0 whenever x_rvalid=0.
REQ-029 Writes produce no response; a read issued the cycle after a write to the same address returns the new data.
REQ-030 Back-to-back reads from alternating requesters return data in grant order, each exactly one cycle after its grant.

Reset
REQ-031 rst_n low immediately sets: state INIT, counter 0, init_done 0, pointer to A, all ready/rvalid/mem_load 0, rdata 0.
REQ-032 Reset mid-INIT restarts the clear from address 0; reset in RUN drops any in-flight read response (no rvalid after release).

Structure
REQ-033 A shared package holds DWIDTH/AWIDTH/WORDS defaults and the INIT/RUN state encoding.
REQ-034 The two-way round-robin grant logic (valids + pointer -> grant, next pointer) is one sub-module, rr_pick2.
REQ-035 The RAM is external; mem_arb2 contains no storage array.

Verification
REQ-036 Release rst_n, no requests -> mem_addr sweeps 0..4095 with mem_load=1, mem_d=0; init_done rises 4096 cycles after release.
REQ-037 a_valid held high during INIT -> a_ready=0 until RUN, then accepted in the first RUN cycle.
REQ-038 A writes 0x1234 at 0x010, next cycle A reads 0x010 -> a_rvalid=1 one cycle after the read grant with a_rdata=0x1234; b_rvalid stays 0.
REQ-039 A and B both valid reads for 6 cycles -> grants A,B,A,B,A,B; rvalid alternates a,b one cycle later; then only B valid for 3 cycles -> B granted all 3 cycles.
REQ-040 rst_n pulsed low when the INIT counter is 100 -> outputs clear asynchronously; after release the sweep restarts at 0 and init_done stays 0 for 4096 cycles.
REQ-041 rst_n pulsed low the cycle after a B read grant -> no b_rvalid after release; init re-runs.
